// File: rtl/priority_pkg.sv
// Shared constants and helpers for the pending-request priority encoder and arbiters.
package priority_pkg;

    localparam logic PRI_FIXED = 1'b0;
    localparam logic PRI_RR    = 1'b1;
    localparam int   PRI_MAX_N = 32;

    // Index width for tools lacking $clog2 in constant contexts; never below 1.
    function automatic int pri_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic logic [PRI_MAX_N-1:0] pri_onehot(input int unsigned idx);
        logic [PRI_MAX_N-1:0] one;
        one = {{(PRI_MAX_N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/pri_select.sv
// Combinational selector: first set bit of vec scanning downward from start-1 (wrapping);
// fixed mode scans from N-1 down to 0.
module pri_select
    import priority_pkg::*;
#(
    parameter int N = 8,
    parameter int W = pri_clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         any
);

    logic [PRI_MAX_N-1:0] oh_full;

    // Fixed priority is the round-robin scan with start=0: N-1, N-2, ..., 0.
    always_comb begin
        int s;
        int j;
        idx = '0;
        any = 1'b0;
        s   = (mode == PRI_RR) ? int'(start) : 0;
        j   = 0;
        for (int k = 1; k <= N; k++) begin
            j = s - k;
            if (j < 0) j = j + N;
            if (!any && vec[j[W-1:0]]) begin
                any = 1'b1;
                idx = j[W-1:0];
            end
        end
    end

    assign oh_full = pri_onehot(int'(idx));
    assign onehot  = any ? oh_full[N-1:0] : '0;

endmodule

// File: rtl/priority_encoder_q.sv
// Registered priority encoder: latches request pulses and presents one pending index per
// valid/ready handshake. Optional PRI_DROP_CNT_EN adds a saturating merged-request counter.
module priority_encoder_q
    import priority_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int RR = 0,
    localparam int W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i,
    input  logic         rdy,
    output logic [W-1:0] o,
    output logic         val,
    output logic [N-1:0] pend
`ifdef PRI_DROP_CNT_EN
    ,
    output logic [7:0]   drop_cnt
`endif
);

    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_1h;
    logic         sel_any;
    logic         grant;
    logic [N-1:0] grant_1hot;
    logic [W-1:0] last;

    pri_select #(.N(N), .W(W)) u_sel (
        .vec    (pend),
        .start  (last),
        .mode   ((RR == 1) ? PRI_RR : PRI_FIXED),
        .idx    (sel_idx),
        .onehot (sel_1h),
        .any    (sel_any)
    );

    // val doubles as the EMPTY/HOLD state; a grant happens whenever the output slot frees up.
    assign grant      = sel_any && (!val || rdy);
    assign grant_1hot = grant ? sel_1h : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            o    <= '0;
            val  <= 1'b0;
            last <= W'(N-1);
        end else begin
            // A new request on the bit being granted survives as a fresh event.
            pend <= (pend & ~grant_1hot) | i;
            if (grant) begin
                o    <= sel_idx;
                val  <= 1'b1;
                last <= sel_idx;
            end else if (rdy) begin
                val  <= 1'b0;
            end
        end
    end

`ifdef PRI_DROP_CNT_EN
    logic [N-1:0] merged;
    logic [8:0]   cnt_sum;

    assign merged  = i & pend & ~grant_1hot;
    assign cnt_sum = {1'b0, drop_cnt} + 9'($countones(merged));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else        drop_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_priority_encoder_q.sv
// Bench for priority_encoder_q: fixed and round-robin instances driven in parallel, checked
// against a behavioural model plus literal expectations.
module tb_priority_encoder_q;

    localparam int N = 8;
    localparam int W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] i = '0;
    logic rdy = 1'b0;

    logic [1:0][W-1:0] d_o;
    logic [1:0]        d_val;
    logic [1:0][N-1:0] d_pend;
`ifdef PRI_DROP_CNT_EN
    logic [1:0][7:0]   d_drop;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    priority_encoder_q #(.N(N), .RR(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .i(i), .rdy(rdy),
        .o(d_o[0]), .val(d_val[0]), .pend(d_pend[0])
`ifdef PRI_DROP_CNT_EN
        , .drop_cnt(d_drop[0])
`endif
    );

    priority_encoder_q #(.N(N), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .i(i), .rdy(rdy),
        .o(d_o[1]), .val(d_val[1]), .pend(d_pend[1])
`ifdef PRI_DROP_CNT_EN
        , .drop_cnt(d_drop[1])
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = fixed, 1 = round-robin) -------------
    logic [N-1:0] m_pend [2];
    logic         m_val  [2];
    int           m_o    [2];
    int           m_last [2];
    int           m_drop [2];

    // First pending source in service order; -1 when nothing is pending.
    function automatic int pick(input logic [N-1:0] p, input int last, input int mode);
        int idx;
        for (int d = 1; d <= N; d++) begin
            idx = (mode == 0) ? (N - d) : ((last - d + N) % N);
            if (p[idx[W-1:0]]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_pend[m] = '0; m_val[m] = 1'b0; m_o[m] = 0; m_last[m] = N - 1; m_drop[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int g;
                logic [N-1:0] gmask;
                logic [N-1:0] p;
                p = m_pend[m];
                g = (!m_val[m] || rdy) ? pick(p, m_last[m], m) : -1;
                gmask = '0;
                if (g >= 0) gmask[g[W-1:0]] = 1'b1;
                m_drop[m] = m_drop[m] + $countones(i & p & ~gmask);
                if (m_drop[m] > 255) m_drop[m] = 255;
                if (g >= 0) begin
                    m_o[m] = g; m_val[m] = 1'b1; m_last[m] = g;
                end else if (rdy) begin
                    m_val[m] = 1'b0;
                end
                m_pend[m] = (p & ~gmask) | i;
            end
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            chk(m ? "rr_val" : "fix_val", int'(d_val[m]), int'(m_val[m]));
            chk(m ? "rr_pend" : "fix_pend", int'(d_pend[m]), int'(m_pend[m]));
            if (m_val[m]) chk(m ? "rr_o" : "fix_o", int'(d_o[m]), m_o[m]);
`ifdef PRI_DROP_CNT_EN
            chk(m ? "rr_drop" : "fix_drop", int'(d_drop[m]), m_drop[m]);
`endif
        end
    end

    // ---------------- directed + random stimulus ----------------
    int rr_seq [9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
    int fix_seq[3] = '{5, 2, 1};

    initial begin
        @(negedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rst_val", int'(d_val[m]), 0);
            chk("rst_pend", int'(d_pend[m]), 0);
            chk("rst_o", int'(d_o[m]), 0);
        end
        rst_n = 1'b1;

        // fixed order 5,2,1 then empty
        i = 8'b0010_0110; rdy = 1'b1;
        @(negedge clk); i = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("seq_val", int'(d_val[0]), 1);
            chk("seq_o", int'(d_o[0]), fix_seq[k]);
        end
        @(negedge clk);
        chk("seq_empty", int'(d_val[0]), 0);

        // hold with rdy low
        rdy = 1'b0; i = 8'h80;
        @(negedge clk); i = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_o", int'(d_o[0]), 7);
            chk("hold_val", int'(d_val[0]), 1);
        end
        i = 8'h01;
        @(negedge clk); i = '0;
        chk("hold_o2", int'(d_o[0]), 7);
        rdy = 1'b1;
        @(negedge clk);
        chk("hold_next", int'(d_o[0]), 0);
        chk("hold_next_val", int'(d_val[0]), 1);
        @(negedge clk);
        chk("hold_drain", int'(d_val[0]), 0);

        // asynchronous reset in the middle of a hold
        rdy = 1'b0; i = 8'h80;
        @(negedge clk); i = 8'h5A;
        @(negedge clk); i = '0;
        chk("pre_rst_pend", int'(d_pend[0]), 8'h5A);
        chk("pre_rst_val", int'(d_val[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("async_pend", int'(d_pend[m]), 0);
            chk("async_val", int'(d_val[m]), 0);
            chk("async_o", int'(d_o[m]), 0);
        end
        @(negedge clk); rst_n = 1'b1;

        // round-robin under full load
        i = 8'hFF; rdy = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rr_seq", int'(d_o[1]), rr_seq[k]);
            chk("fix_full", int'(d_o[0]), 7);
        end
        i = '0;
        repeat (12) @(negedge clk);

        // re-request on the granting edge
        i = 8'h08;
        @(negedge clk);
        @(negedge clk); i = '0;
        chk("rereq_pend3", int'(d_pend[0][3]), 1);
        chk("rereq_o", int'(d_o[0]), 3);
        @(negedge clk);
        chk("rereq_again", int'(d_o[0]), 3);
        chk("rereq_val", int'(d_val[0]), 1);
        chk("rereq_pend", int'(d_pend[0]), 0);
        @(negedge clk);
        chk("rereq_done", int'(d_val[0]), 0);

        // randomized traffic with occasional async reset
        for (int c = 0; c < 3000; c++) begin
            i   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk); rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        i = '0;

`ifdef PRI_DROP_CNT_EN
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rdy = 1'b0; i = 8'h80;
        @(negedge clk); i = '0;
        @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            i = 8'h01;
            @(negedge clk); i = '0;
            @(negedge clk);
        end
        chk("drop_sat_fix", int'(d_drop[0]), 255);
        chk("drop_sat_rr", int'(d_drop[1]), 255);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
